// File: rtl/dmem_latency_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_latency_ctrl
//  Function : Byte/half/word data memory with configurable access latency,
//             stall/ready handshake and a sticky misaligned/illegal fault flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_latency_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wd,
  input  logic [2:0]        funct3,
  output logic [31:0]       rd,
  output logic              stall,
  output logic              ready,
  output logic              misalign,
  output logic              fault
);

  localparam int c_idx_w = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wd;
  logic [2:0]          r_f3;
  logic                r_store;
  logic [31:0]         r_rd;
  logic                r_ready;
  logic                r_fault;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_req;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_commit;
  logic [c_idx_w-1:0]  w_idx;
  logic [31:0]         w_word;
  logic [31:0]         w_shift;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;

  assign w_req = re | we;

  // A store wins when both requests are high, so legality follows we.
  always_comb begin
    w_illegal = 1'b0;
    if (we) begin
      w_illegal = funct3[2] | (funct3[1:0] == 2'b11);
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end
  end

  assign w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                        ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign misalign = (r_state == S_IDLE) & w_req & (w_misaligned | w_illegal);
  assign stall    = ((r_state == S_IDLE) & w_req & ~misalign) | (r_state == S_BUSY);
  assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);

  assign w_idx   = r_addr[ADDR_W-1:2];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (r_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wd[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wd[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wd;
      end
    endcase
  end

  // The array has no reset; an aborted access never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit && r_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wd    <= 32'd0;
      r_f3    <= 3'd0;
      r_store <= 1'b0;
      r_rd    <= 32'd0;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (misalign) r_fault <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_req && !misalign) begin
            r_addr  <= addr;
            r_wd    <= wd;
            r_f3    <= funct3;
            r_store <= we;
            r_cnt   <= 4'(LATENCY);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_store) r_rd <= w_load;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd    = r_rd;
  assign ready = r_ready;
  assign fault = r_fault;

endmodule
`default_nettype wire
